// File: rtl/vga_timing_gen.sv
// VGA raster timing generator gated by PLL lock. Waits for a stable lock,
// then free-runs x/y counters with registered, zero-skew sync/blank strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [9:0]    H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS       = 10'(H_ACTIVE);
    localparam logic [9:0]    V_VIS       = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_START    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END      = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_START    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END      = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] settle_cnt, settle_nxt;
    logic [9:0]    x_nxt, y_nxt;
    logic          run_nxt;
    logic          hsync_nxt, vsync_nxt, video_on_nxt, frame_start_nxt;

    // Counters default to zero so every exit from RUN clears them on the same edge.
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        x_nxt      = '0;
        y_nxt      = '0;
        case (state)
            WAIT_LOCK: begin
                if (locked) begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
            end
            SETTLE: begin
                if (!locked) begin
                    state_nxt  = WAIT_LOCK;
                    settle_nxt = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt  = RUN;
                    settle_nxt = '0;
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!locked) begin
                    state_nxt = WAIT_LOCK;
                end else begin
                    x_nxt = (x == H_LAST) ? '0 : x + 1'b1;
                    if (x == H_LAST)
                        y_nxt = (y == V_LAST) ? '0 : y + 1'b1;
                    else
                        y_nxt = y;
                end
            end
            default: begin
                state_nxt  = WAIT_LOCK;
                settle_nxt = '0;
            end
        endcase
    end

    // Strobes are decoded from the next counter values and registered beside
    // them, so every output changes on the same edge with no decode lag.
    always_comb begin
        run_nxt         = (state_nxt == RUN);
        hsync_nxt       = !(run_nxt && (x_nxt >= HS_START) && (x_nxt < HS_END));
        vsync_nxt       = !(run_nxt && (y_nxt >= VS_START) && (y_nxt < VS_END));
        video_on_nxt    = run_nxt && (x_nxt < H_VIS) && (y_nxt < V_VIS);
        frame_start_nxt = run_nxt && (x_nxt == '0) && (y_nxt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            settle_cnt  <= '0;
            x           <= '0;
            y           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_nxt;
            settle_cnt  <= settle_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            video_on    <= video_on_nxt;
            frame_start <= frame_start_nxt;
            running     <= run_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: lock/settle sequencing, line and frame
// timing (short vertical raster), lock loss and asynchronous reset.
module tb_vga_timing_gen;

    // Vertical raster shortened to keep a full frame cheap: 12+4+2+3 = 21 lines.
    localparam int TV_ACTIVE = 12;
    localparam int TV_FP     = 4;
    localparam int TV_SYNC   = 2;
    localparam int TV_BP     = 3;

    localparam int LINE      = 800;
    localparam int FRAME     = 16800;   // 21 * 800
    localparam int HS_FALL   = 656;
    localparam int HS_RISE   = 752;
    localparam int VIS_LINE  = 640;
    localparam int VS_Y      = 16;      // 12 + 4
    localparam int VS_LOW    = 1600;    // 2 lines
    localparam int VID_FRAME = 7680;    // 640 * 12

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       hsync, vsync, video_on, frame_start, running;
    logic [9:0] x, y;

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(
        .V_ACTIVE(TV_ACTIVE), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP)
    ) dut (
        .clk(clk), .rst(rst), .locked(locked),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .x(x), .y(y), .frame_start(frame_start), .running(running)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " running"}, 32'(running), 0);
        chk({tag, " x"}, 32'(x), 0);
        chk({tag, " y"}, 32'(y), 0);
        chk({tag, " hsync"}, 32'(hsync), 1);
        chk({tag, " vsync"}, 32'(vsync), 1);
        chk({tag, " video_on"}, 32'(video_on), 0);
        chk({tag, " frame_start"}, 32'(frame_start), 0);
    endtask

    // First edge enters SETTLE; running must stay low for 15 more and rise on the 16th.
    task automatic settle_seq(input string tag);
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk({tag, " running before settle done"}, 32'(running), 0);
        tick();
        chk({tag, " running"}, 32'(running), 1);
        chk({tag, " frame_start"}, 32'(frame_start), 1);
        chk({tag, " x0"}, 32'(x), 0);
        chk({tag, " y0"}, 32'(y), 0);
    endtask

    initial begin
        int fall_x, rise_x, vis, fs, n, vs_low, vs_x, vs_y, vid;
        logic prev_h;

        // Reset state
        locked = 1'b1;
        #12;
        chk_idle("reset");
        tick();
        chk_idle("reset held");
        rst = 1'b0;

        // Locked throughout: RUN 16 edges after the first locked edge
        settle_seq("startup");

        // Line timing over line 0
        fall_x = 1023; rise_x = 1023; vis = 0; fs = 0;
        prev_h = hsync;
        for (int i = 0; i < LINE; i++) begin
            if (prev_h && !hsync) fall_x = int'(x);
            if (!prev_h && hsync) rise_x = int'(x);
            vis += int'(video_on);
            fs  += int'(frame_start);
            prev_h = hsync;
            tick();
        end
        chk("hsync fall x", 32'(fall_x), HS_FALL);
        chk("hsync rise x", 32'(rise_x), HS_RISE);
        chk("video_on per line", 32'(vis), VIS_LINE);
        chk("frame_start in line", 32'(fs), 1);
        chk("line period x", 32'(x), 0);
        chk("line period y", 32'(y), 1);

        // Remainder of frame 0 up to the next frame_start
        n = 0;
        while (n < FRAME && !frame_start) begin
            tick();
            n++;
        end
        chk("cycles to next frame_start", 32'(n), FRAME - LINE);

        // Full frame
        vs_low = 0; vs_x = 1023; vs_y = 1023; vid = 0; fs = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (!vsync) begin
                if (vs_low == 0) begin
                    vs_x = int'(x);
                    vs_y = int'(y);
                end
                vs_low++;
            end
            vid += int'(video_on);
            fs  += int'(frame_start);
            tick();
        end
        chk("vsync low cycles", 32'(vs_low), VS_LOW);
        chk("vsync start x", 32'(vs_x), 0);
        chk("vsync start y", 32'(vs_y), VS_Y);
        chk("video_on per frame", 32'(vid), VID_FRAME);
        chk("frame_start per frame", 32'(fs), 1);
        chk("frame period fs", 32'(frame_start), 1);
        chk("frame period x", 32'(x), 0);
        chk("frame period y", 32'(y), 0);

        // Lock lost mid-frame at (300,15)
        n = 0;
        while (n < FRAME && !(x == 10'd300 && y == 10'd15)) begin
            tick();
            n++;
        end
        chk("reached (300,15)", 32'(n < FRAME), 1);
        locked = 1'b0;
        tick();
        chk_idle("lock lost");
        locked = 1'b1;
        settle_seq("relock");

        // Lock glitch at settle count 10 restarts the settle window
        locked = 1'b0;
        tick();
        chk("drop to wait", 32'(running), 0);
        locked = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        locked = 1'b0;
        tick();
        chk_idle("settle glitch");
        locked = 1'b1;
        settle_seq("resettle");

        // Asynchronous reset between edges, mid-line
        for (int i = 0; i < 100; i++) tick();
        chk("pre-reset x", 32'(x), 100);
        #2 rst = 1'b1;
        #1;
        chk_idle("async rst");
        #2 rst = 1'b0;
        settle_seq("post rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
